// File: rtl/audio_lpf_scheduler_pkg.sv
// Shared constants, FSM encoding and round-robin helper for the time-multiplexed
// boxcar low-pass filter used in the sound mixer.
package audio_lpf_pkg;

  localparam int TAPS     = 8;
  localparam int TAP_LOG2 = 3;
  localparam int MAX_CH   = 8;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  // Unused upper request bits are zero, so a modulo-8 scan gives the same
  // answer as a modulo-NCH scan for any NCH up to 8.
  function automatic logic [2:0] rr_pick(input logic [MAX_CH-1:0] req,
                                         input logic [2:0]        last);
    logic [2:0] idx;
    logic [2:0] pick;
    logic       found;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= MAX_CH; i++) begin
      idx = last + 3'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/audio_lpf_scheduler_if.sv
// Request/grant and filtered-output bundle between the audio sources and the
// shared low-pass filter.
interface audio_lpf_scheduler_if #(
  parameter int MSBI = 15,
  parameter int NCH  = 4
);
  localparam int CH_W = $clog2(NCH);

  logic [NCH-1:0]          REQ;
  logic [NCH*(MSBI+1)-1:0] IDATA;
  logic [NCH-1:0]          ACK;
  logic [MSBI:0]           ODATA;
  logic [CH_W-1:0]         OCH;
  logic                    OVALID;

  modport master (output REQ, IDATA, input ACK, ODATA, OCH, OVALID);
  modport slave  (input REQ, IDATA, output ACK, ODATA, OCH, OVALID);

endinterface

// File: rtl/audio_lpf_hist_ram.sv
// Sample history store for all channels: single-port RAM with registered read.
module audio_lpf_hist_ram #(
  parameter int AW    = 5,
  parameter int DW    = 16,
  parameter int DEPTH = 32
) (
  input  logic          CLK21M,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge CLK21M) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/audio_lpf_scheduler.sv
// One running-sum 8-tap boxcar filter shared round-robin between NCH sources;
// each channel keeps its own history slice, write pointer and running sum.
module audio_lpf_scheduler
  import audio_lpf_pkg::*;
#(
  parameter int MSBI = 15,
  parameter int NCH  = 4
) (
  input  logic                  CLK21M,
  input  logic                  RESET,
  audio_lpf_scheduler_if.slave  bus
);

  localparam int CH_W  = $clog2(NCH);
  localparam int DW    = MSBI + 1;
  localparam int SUM_W = MSBI + 4;
  localparam int AW    = CH_W + TAP_LOG2;
  localparam int DEPTH = NCH * TAPS;

  function automatic logic [MSBI:0] div8_trunc(input logic [SUM_W-1:0] s);
    return s[MSBI+3:3];
  endfunction

  state_t                 state_q, state_d;
  logic [CH_W-1:0]        last_grant;
  logic [CH_W-1:0]        ch_p0;
  logic [DW-1:0]          new_s_p0;
  logic [TAP_LOG2-1:0]    ptr_r [NCH];
  logic [SUM_W-1:0]       sum_r [NCH];
  logic                   busy_clr;
  logic [AW-1:0]          clr_cnt;
  logic [NCH-1:0]         ack_r;
  logic [MSBI:0]          odata_r;
  logic [CH_W-1:0]        och_r;
  logic                   ovalid_r;

  logic [2:0]             pick8;
  logic [CH_W-1:0]        pick;
  logic                   grant;
  logic                   ram_we;
  logic [AW-1:0]          ram_addr;
  logic [DW-1:0]          ram_din;
  logic [DW-1:0]          ram_dout;
  logic [SUM_W-1:0]       calc_s;

  assign pick8 = rr_pick(MAX_CH'(bus.REQ), 3'(last_grant));
  assign pick  = pick8[CH_W-1:0];

  always_ff @(posedge CLK21M or posedge RESET) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // The RAM port is shared by the clear sequencer, the grant read and the CALC write.
  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    ram_we   = 1'b0;
    ram_addr = {pick, ptr_r[pick]};
    ram_din  = new_s_p0;
    calc_s   = sum_r[ch_p0] + SUM_W'(new_s_p0) - SUM_W'(ram_dout);
    if (busy_clr) begin
      ram_we   = 1'b1;
      ram_addr = clr_cnt;
      ram_din  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|bus.REQ) begin
            grant   = 1'b1;
            state_d = CALC;
          end
        end
        CALC: begin
          ram_we   = 1'b1;
          ram_addr = {ch_p0, ptr_r[ch_p0]};
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Grant stage: capture the winning channel and its sample.
  always_ff @(posedge CLK21M) begin
    if (grant) begin
      ch_p0    <= pick;
      new_s_p0 <= bus.IDATA[pick*DW +: DW];
    end
  end

  // Calc stage: update channel state and present the filtered sample.
  always_ff @(posedge CLK21M or posedge RESET) begin
    if (RESET) begin
      ack_r      <= '0;
      ovalid_r   <= 1'b0;
      odata_r    <= '0;
      och_r      <= '0;
      last_grant <= CH_W'(NCH - 1);
      busy_clr   <= 1'b1;
      clr_cnt    <= '0;
      for (int n = 0; n < NCH; n++) begin
        ptr_r[n] <= '0;
        sum_r[n] <= '0;
      end
    end else begin
      ack_r    <= '0;
      ovalid_r <= 1'b0;
      if (busy_clr) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (clr_cnt == AW'(DEPTH - 1)) busy_clr <= 1'b0;
      end
      if (grant) begin
        ack_r      <= NCH'(1) << pick;
        last_grant <= pick;
      end
      if (state_q == CALC) begin
        sum_r[ch_p0] <= calc_s;
        ptr_r[ch_p0] <= ptr_r[ch_p0] + 1'b1;
        odata_r      <= div8_trunc(calc_s);
        och_r        <= ch_p0;
        ovalid_r     <= 1'b1;
      end
    end
  end

  assign bus.ACK    = ack_r;
  assign bus.ODATA  = odata_r;
  assign bus.OCH    = och_r;
  assign bus.OVALID = ovalid_r;

  audio_lpf_hist_ram #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_hist_ram (
    .CLK21M (CLK21M),
    .we     (ram_we),
    .addr   (ram_addr),
    .din    (ram_din),
    .dout   (ram_dout)
  );

endmodule

// File: tb/tb_audio_lpf_scheduler.sv
// Directed bench for the shared audio low-pass filter: step, full scale,
// isolation, arbitration order, latency and reset during a transaction.
module tb_audio_lpf_scheduler;

  localparam int MSBI = 15;
  localparam int NCH  = 4;
  localparam int BOUND = 200;

  logic CLK21M = 1'b0;
  logic RESET  = 1'b1;

  audio_lpf_scheduler_if #(.MSBI(MSBI), .NCH(NCH)) bus ();

  audio_lpf_scheduler #(.MSBI(MSBI), .NCH(NCH)) dut (
    .CLK21M (CLK21M),
    .RESET  (RESET),
    .bus    (bus)
  );

  always #5 CLK21M = ~CLK21M;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one sample on a channel and checks the filtered result it produces.
  task automatic xfer(input int ch, input logic [15:0] d, input logic [15:0] exp_od,
                      input string tag, output int waits);
    bus.REQ[ch] = 1'b1;
    bus.IDATA[ch*16 +: 16] = d;
    waits = 0;
    do begin
      @(posedge CLK21M); #1;
      waits++;
    end while (bus.ACK !== 4'(1 << ch) && waits < BOUND);
    if (waits >= BOUND) chk({tag, "_ack_timeout"}, 32'(waits), 32'(0));
    chk({tag, "_ov_pulse"}, 32'(bus.OVALID), 32'(0));
    @(posedge CLK21M); #1;
    bus.REQ[ch] = 1'b0;
    chk({tag, "_ovalid"}, 32'(bus.OVALID), 32'(1));
    chk({tag, "_ack_drop"}, 32'(bus.ACK), 32'(0));
    chk({tag, "_och"}, 32'(bus.OCH), 32'(ch));
    chk({tag, "_odata"}, 32'(bus.ODATA), 32'(exp_od));
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    @(posedge CLK21M); #1;
    RESET = 1'b0;
    repeat (40) @(posedge CLK21M);
    #1;
  endtask

  logic [15:0] fs_up   [8] = '{16'h1FFF, 16'h3FFF, 16'h5FFF, 16'h7FFF,
                               16'h9FFF, 16'hBFFF, 16'hDFFF, 16'hFFFF};
  logic [15:0] fs_down [8] = '{16'hDFFF, 16'hBFFF, 16'h9FFF, 16'h7FFF,
                               16'h5FFF, 16'h3FFF, 16'h1FFF, 16'h0000};
  logic [15:0] arb_exp [8] = '{16'h0010, 16'h0020, 16'h0040, 16'h0080,
                               16'h0020, 16'h0040, 16'h0080, 16'h0100};

  initial begin
    int w;
    bus.REQ   = '0;
    bus.IDATA = '0;

    #12;
    chk("rst_ack",    32'(bus.ACK),    32'(0));
    chk("rst_ovalid", 32'(bus.OVALID), 32'(0));
    chk("rst_odata",  32'(bus.ODATA),  32'(0));
    chk("rst_och",    32'(bus.OCH),    32'(0));
    @(posedge CLK21M); #1;
    RESET = 1'b0;
    repeat (40) @(posedge CLK21M);
    #1;

    for (int k = 0; k < 10; k++) begin
      xfer(0, 16'h0100, (k < 8) ? 16'(16'h0020 * (k + 1)) : 16'h0100, "step", w);
      if (k == 0) chk("latency_ack", 32'(w), 32'(1));
    end

    for (int k = 0; k < 8; k++) xfer(1, 16'h0800, 16'(16'h0100 * (k + 1)), "iso_ch1", w);
    xfer(2, 16'h0008, 16'h0001, "iso_ch2", w);
    xfer(1, 16'h0800, 16'h0800, "iso_ch1_again", w);

    for (int k = 0; k < 8; k++) xfer(3, 16'hFFFF, fs_up[k], "fs_up", w);
    for (int k = 0; k < 8; k++) xfer(3, 16'h0000, fs_down[k], "fs_down", w);

    bus.REQ[0] = 1'b1;
    bus.IDATA[15:0] = 16'h1234;
    w = 0;
    do begin
      @(posedge CLK21M); #1;
      w++;
    end while (bus.ACK !== 4'b0001 && w < BOUND);
    if (w >= BOUND) chk("midrst_ack_timeout", 32'(w), 32'(0));
    RESET = 1'b1;
    #1;
    chk("midrst_ack",    32'(bus.ACK),    32'(0));
    chk("midrst_ovalid", 32'(bus.OVALID), 32'(0));
    @(posedge CLK21M); #1;
    chk("midrst_no_ov", 32'(bus.OVALID), 32'(0));
    bus.IDATA[15:0] = 16'h0800;
    RESET = 1'b0;
    w = 0;
    do begin
      @(posedge CLK21M); #1;
      w++;
    end while (bus.ACK !== 4'b0001 && w < BOUND);
    chk("midrst_clear_wait", 32'(w), 32'(NCH * 8 + 1));
    @(posedge CLK21M); #1;
    bus.REQ[0] = 1'b0;
    chk("midrst_ovalid2", 32'(bus.OVALID), 32'(1));
    chk("midrst_och",     32'(bus.OCH),    32'(0));
    chk("midrst_odata",   32'(bus.ODATA),  32'(16'h0100));

    do_reset();
    bus.IDATA = {16'h0400, 16'h0200, 16'h0100, 16'h0080};
    bus.REQ   = 4'hF;
    for (int k = 1; k <= 16; k++) begin
      @(posedge CLK21M); #1;
      if (k % 2 == 1) begin
        chk("arb_ack",    32'(bus.ACK),    32'(1 << (((k - 1) / 2) % 4)));
        chk("arb_ov_low", 32'(bus.OVALID), 32'(0));
      end else begin
        chk("arb_ovalid",  32'(bus.OVALID), 32'(1));
        chk("arb_ack_low", 32'(bus.ACK),    32'(0));
        chk("arb_och",     32'(bus.OCH),    32'((k / 2 - 1) % 4));
        chk("arb_odata",   32'(bus.ODATA),  32'(arb_exp[k / 2 - 1]));
      end
    end
    bus.REQ = '0;
    @(posedge CLK21M); #1;
    @(posedge CLK21M); #1;
    chk("arb_quiet_ack", 32'(bus.ACK), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
